lifo_pop_stream: RTL and testbench
==================================

LIFO_POP_STREAM -- requirements
Module: lifo_pop_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width, matching the attached LIFO's data width.
REQ-002 SHALL have parameter CNT_W, default 16: width of the delivered-item counter.
REQ-003 SHALL have port clk  input  1: the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous assert, active-low, synchronous deassert handled by the system.
REQ-005 SHALL have port drain_en  input  1: 1 = permitted to pop the LIFO.
REQ-006 SHALL have port lifo_empty  input  1: empty flag of the upstream LIFO.
REQ-007 SHALL have port lifo_full  input  1: full flag of the upstream LIFO.
REQ-008 SHALL have port lifo_push  input  1: a copy of the push strobe driven into the LIFO by its producer.
REQ-009 SHALL have port lifo_dout  input  WIDTH: registered read data from the LIFO.
REQ-010 SHALL have port lifo_pop  output  1: pop strobe to the LIFO.
REQ-011 SHALL have port m_valid  output  1: output data valid.
REQ-012 SHALL have port m_ready  input  1: downstream ready.
REQ-013 SHALL have port m_data  output  WIDTH: output data.
REQ-014 SHALL have port busy  output  1: 1 when state is not IDLE.
REQ-015 SHALL have port deliv_cnt  output  CNT_W: count of completed output transfers.

Function
REQ-016 Pop effectiveness: a pop SHALL be effective only when lifo_pop=1, lifo_empty=0, and NOT (lifo_push=1 AND lifo_full=0); this matches the LIFO, where push has priority.
REQ-017 Data latency: after an effective pop in cycle N, lifo_dout SHALL be captured at the end of cycle N+1; an inflight bit, registered from the effective pop, marks the pending capture.
REQ-018 Buffer: captured words SHALL enter a 2-entry FIFO skid buffer; occ is its occupancy (0..2); m_valid SHALL be (occ != 0); m_data SHALL be the head entry.
REQ-019 Pop request: lifo_pop = drain_en AND NOT lifo_empty AND (occ + inflight - deq) < 2, where deq = m_valid AND m_ready; lifo_pop MAY depend combinationally on m_ready.
REQ-020 Throughput: with drain_en=1, the LIFO non-empty and m_ready held at 1, the block SHALL sustain one transfer per cycle after a 2-cycle initial latency from the first pop.
REQ-021 Stability: while m_valid=1 and m_ready=0, m_data and m_valid SHALL hold.
REQ-022 Order: words SHALL be output in the order they were popped, i.e. LIFO order; there SHALL be no reordering within the buffer.
REQ-023 Simultaneous capture and deq: a capture and a deq in the same cycle SHALL leave occ unchanged; occ SHALL never exceed 2, and a capture arriving at occ=2 is impossible by REQ-019.
REQ-024 Counter: deliv_cnt SHALL increment by 1 per deq and wrap modulo 2^CNT_W without saturation.
REQ-025 FSM states: IDLE, DRAIN, FLUSH.
REQ-026 FSM, IDLE->DRAIN: when drain_en=1 and lifo_empty=0.
REQ-027 FSM, DRAIN->FLUSH: when drain_en=0, or lifo_empty=1 with no effective pop.
REQ-028 FSM, FLUSH->DRAIN: when drain_en=1 and lifo_empty=0.
REQ-029 FSM, FLUSH->IDLE: when occ=0, inflight=0 and no capture is pending.
REQ-030 Drain disable: deasserting drain_en SHALL stop new pops in the same cycle; inflight and buffered words SHALL still be delivered.
REQ-031 Push/pop collision: a dropped pop (lifo_push wins) SHALL NOT set inflight, and SHALL NOT capture or count anything.

Reset
REQ-032 On rstn=0, immediately and independent of clk: state=IDLE, occ=0, inflight=0, buffer contents=0, deliv_cnt=0, m_valid=0, m_data=0, lifo_pop=0, busy=0.
REQ-033 Reset mid-transfer SHALL discard buffered and inflight words; the LIFO shares rstn and is cleared too, so no recovery is required.

Structure
REQ-034 Package lifo_pkg SHALL hold the WIDTH default, the FSM state enumeration and CNT_W default.
REQ-035 The 2-entry skid buffer SHALL be a separate sub-module, lifo_skid2, with its own push/pop/occ interface; all other logic SHALL live in lifo_pop_stream.
REQ-036 The implementation SHALL be paired with the LIFO (WIDTH=8, DEPTH=8) in the bench.

Verification
REQ-037 Basic drain: push 0x11,0x22,0x33 into the LIFO, then drain_en=1, m_ready=1 -> m_data 0x33,0x22,0x11 on consecutive cycles; first m_valid 2 cycles after the first pop; deliv_cnt=3; IDLE at the end.
REQ-038 Backpressure: 5 items, m_ready=0 for 4 cycles -> occ reaches 2, lifo_pop=0, m_data stable; after m_ready=1 all 5 words are output in LIFO order with none lost.
REQ-039 Collision: lifo_push=1 with lifo_full=0 in the same cycle as lifo_pop -> no capture; the pushed word is output first on the next pop.
REQ-040 Disable mid-drain: drain_en drops with inflight=1 and occ=1 -> exactly 2 more words are output, then IDLE, and the LIFO retains the remainder.
REQ-041 Async reset: rstn low during a burst with occ=2 -> m_valid=0 and deliv_cnt=0 before the next clk edge.
REQ-042 Counter wrap: with CNT_W=4, 17 deliveries -> deliv_cnt=1.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared defaults and FSM state encoding for the LIFO pop-stream adapter.
package lifo_pkg;

    localparam int unsigned LIFO_WIDTH = 8;
    localparam int unsigned LIFO_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/lifo_skid2.sv
// Two-entry in-order FIFO used as the output skid buffer; e0 is always the head.
module lifo_skid2
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH = LIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;

    // The parent never pushes at occ=2 nor pops at occ=0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e0  <= '0;
            e1  <= '0;
            occ <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= din;
                    else             e1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = e0;

endmodule

// File: rtl/lifo_pop_stream.sv
// Pops a registered-read LIFO and presents the words as a valid/ready stream.
module lifo_pop_stream
    import lifo_pkg::*;
#(
    parameter int unsigned WIDTH = LIFO_WIDTH,
    parameter int unsigned CNT_W = LIFO_CNT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             drain_en,
    input  logic             lifo_empty,
    input  logic             lifo_full,
    input  logic             lifo_push,
    input  logic [WIDTH-1:0] lifo_dout,
    output logic             lifo_pop,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [CNT_W-1:0] deliv_cnt
);

    state_t     state;
    state_t     state_nxt;
    logic       inflight;
    logic [1:0] occ;
    logic       deq;
    logic       eff_pop;
    logic [2:0] pending;

    assign m_valid = (occ != 2'd0);
    assign deq     = m_valid & m_ready;
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    assign lifo_pop = rstn & drain_en & ~lifo_empty & (pending < 3'd2);
    // A producer push to a non-full LIFO wins the cycle and cancels the pop.
    assign eff_pop = lifo_pop & ~lifo_empty & ~(lifo_push & ~lifo_full);
    assign busy    = (state != IDLE);

    lifo_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rstn (rstn),
        .push (inflight),
        .din  (lifo_dout),
        .pop  (deq),
        .dout (m_data),
        .occ  (occ)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            deliv_cnt <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= eff_pop;
            if (deq) deliv_cnt <= deliv_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (drain_en && !lifo_empty) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!drain_en || (lifo_empty && !eff_pop)) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (drain_en && !lifo_empty)          state_nxt = DRAIN;
                else if (occ == 2'd0 && !inflight)    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lifo_pop_stream.sv
// Directed bench: behavioural 8x8 LIFO feeding lifo_pop_stream, scoreboard-checked stream.
module tb_lifo_pop_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          drain_en = 1'b0;
    logic          lifo_empty;
    logic          lifo_full;
    logic          lifo_push = 1'b0;
    logic [W-1:0]  push_din = '0;
    logic [W-1:0]  lifo_dout;
    logic          lifo_pop;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          busy;
    logic [CW-1:0] deliv_cnt;

    int unsigned   n_checks = 0;
    int unsigned   n_fail = 0;
    logic [W-1:0]  sb_q[$];
    logic [W-1:0]  exp_word;

    always #5 clk = ~clk;

    lifo_pop_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .drain_en   (drain_en),
        .lifo_empty (lifo_empty),
        .lifo_full  (lifo_full),
        .lifo_push  (lifo_push),
        .lifo_dout  (lifo_dout),
        .lifo_pop   (lifo_pop),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .deliv_cnt  (deliv_cnt)
    );

    // Upstream LIFO, depth 8, registered read, push has priority over pop.
    logic [W-1:0] lmem [8];
    logic [3:0]   lcnt;

    assign lifo_empty = (lcnt == 4'd0);
    assign lifo_full  = (lcnt == 4'd8);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lcnt      <= '0;
            lifo_dout <= '0;
        end else if (lifo_push && !lifo_full) begin
            lmem[lcnt[2:0]] <= push_din;
            lcnt            <= lcnt + 4'd1;
        end else if (lifo_pop && !lifo_empty) begin
            lifo_dout <= lmem[3'(lcnt - 4'd1)];
            lcnt      <= lcnt - 4'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, expected no transfer", m_data);
            end else begin
                exp_word = sb_q.pop_front();
                check("stream_data", {24'd0, m_data}, {24'd0, exp_word});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lifo(input logic [W-1:0] v);
        lifo_push = 1'b1;
        push_din  = v;
        step();
        lifo_push = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        step();
        step();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !m_valid) break;
            step();
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic drain_round(input int unsigned n, input logic [W-1:0] base);
        for (int unsigned i = 0; i < n; i++) push_lifo(W'(base + i));
        for (int i = int'(n) - 1; i >= 0; i--) sb_q.push_back(W'(base + i));
        drain_en = 1'b1;
        m_ready  = 1'b1;
        wait_idle("wrap_idle");
        drain_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_deliv_cnt", {28'd0, deliv_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lifo_pop", {31'd0, lifo_pop}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();

        // Basic drain of 0x11,0x22,0x33.
        push_lifo(8'h11);
        push_lifo(8'h22);
        push_lifo(8'h33);
        sb_q.push_back(8'h33);
        sb_q.push_back(8'h22);
        sb_q.push_back(8'h11);
        drain_en = 1'b1;
        m_ready  = 1'b1;
        #1;
        check("basic_first_pop", {31'd0, lifo_pop}, 32'd1);
        step();
        check("basic_lat1_invalid", {31'd0, m_valid}, 32'd0);
        step();
        check("basic_lat2_valid", {31'd0, m_valid}, 32'd1);
        check("basic_head", {24'd0, m_data}, 32'h33);
        step();
        check("basic_second_valid", {31'd0, m_valid}, 32'd1);
        step();
        check("basic_third_valid", {31'd0, m_valid}, 32'd1);
        wait_idle("basic_idle");
        check("basic_cnt", {28'd0, deliv_cnt}, 32'd3);
        drain_en = 1'b0;

        // Backpressure with 5 items.
        for (int i = 1; i <= 5; i++) push_lifo(W'(8'h40 + i));
        for (int i = 5; i >= 1; i--) sb_q.push_back(W'(8'h40 + i));
        drain_en = 1'b1;
        m_ready  = 1'b0;
        step();
        step();
        step();
        step();
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_no_pop", {31'd0, lifo_pop}, 32'd0);
        check("bp_head", {24'd0, m_data}, 32'h45);
        step();
        check("bp_head_hold", {24'd0, m_data}, 32'h45);
        check("bp_valid_hold", {31'd0, m_valid}, 32'd1);
        m_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_cnt", {28'd0, deliv_cnt}, 32'd8);
        drain_en = 1'b0;

        // Push/pop collision: the pushed word becomes the next popped word.
        push_lifo(8'h51);
        push_lifo(8'h52);
        sb_q.push_back(8'h5A);
        sb_q.push_back(8'h52);
        sb_q.push_back(8'h51);
        lifo_push = 1'b1;
        push_din  = 8'h5A;
        drain_en  = 1'b1;
        #1;
        check("col_pop_req", {31'd0, lifo_pop}, 32'd1);
        step();
        lifo_push = 1'b0;
        step();
        check("col_no_capture", {31'd0, m_valid}, 32'd0);
        step();
        check("col_valid", {31'd0, m_valid}, 32'd1);
        check("col_head", {24'd0, m_data}, 32'h5A);
        wait_idle("col_idle");
        check("col_cnt", {28'd0, deliv_cnt}, 32'd11);
        drain_en = 1'b0;

        // Disable mid-drain with one word buffered and one in flight.
        for (int i = 1; i <= 6; i++) push_lifo(W'(8'h60 + i));
        sb_q.push_back(8'h66);
        sb_q.push_back(8'h65);
        drain_en = 1'b1;
        step();
        step();
        drain_en = 1'b0;
        #1;
        check("dis_no_pop", {31'd0, lifo_pop}, 32'd0);
        check("dis_valid", {31'd0, m_valid}, 32'd1);
        wait_idle("dis_idle");
        check("dis_cnt", {28'd0, deliv_cnt}, 32'd13);
        check("dis_lifo_left", {28'd0, lcnt}, 32'd4);

        // Async reset with the buffer full.
        drain_en = 1'b1;
        m_ready  = 1'b0;
        step();
        step();
        step();
        check("ar_full_valid", {31'd0, m_valid}, 32'd1);
        check("ar_full_no_pop", {31'd0, lifo_pop}, 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_m_valid", {31'd0, m_valid}, 32'd0);
        check("ar_deliv_cnt", {28'd0, deliv_cnt}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        check("ar_m_data", {24'd0, m_data}, 32'd0);
        drain_en = 1'b0;
        step();
        rstn = 1'b1;
        step();

        // Counter wrap: 17 deliveries on a 4-bit counter.
        drain_round(8, 8'h80);
        check("wrap_cnt8", {28'd0, deliv_cnt}, 32'd8);
        drain_round(8, 8'h90);
        check("wrap_cnt16", {28'd0, deliv_cnt}, 32'd0);
        drain_round(1, 8'hA0);
        check("wrap_cnt17", {28'd0, deliv_cnt}, 32'd1);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
